// File: rtl/t_fsk_pkg.sv
// Shared types and defaults for the t_fsk 2-FSK word transmitter.
// Defining T_FSK_PARITY_EN adds the PARITY state used for the 17th (even-parity) bit.
package t_fsk_pkg;

    localparam int WORD_W          = 16;
    localparam int DEF_CLK_PER_BIT = 256;
    localparam int DEF_HALF_1      = 8;
    localparam int DEF_HALF_0      = 32;

`ifdef T_FSK_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/fsk_tone_gen.sv
// Tone generator: square wave starting low, toggling every HALF_1 or HALF_0 clocks.
// restart clears the phase so the next cycle begins a fresh low half-period.
module fsk_tone_gen
    import t_fsk_pkg::*;
#(
    parameter int HALF_1 = DEF_HALF_1,
    parameter int HALF_0 = DEF_HALF_0
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic half_sel,
    output logic tone
);

    localparam int PW = $clog2(HALF_0);
    localparam logic [PW-1:0] LIM_1 = PW'(HALF_1 - 1);
    localparam logic [PW-1:0] LIM_0 = PW'(HALF_0 - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          tone_q, tone_d;
    logic          wrap;

    always_comb begin
        wrap    = (phase_q == (half_sel ? LIM_1 : LIM_0));
        phase_d = wrap ? '0 : phase_q + 1'b1;
        tone_d  = wrap ? ~tone_q : tone_q;
        if (restart) begin
            phase_d = '0;
            tone_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            tone_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tone_q  <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/t_fsk.sv
// 2-FSK serial transmitter: sends 16-bit words MSB first, one tone per bit period.
// Define T_FSK_PARITY_EN to append an even-parity bit as a 17th bit period.
module t_fsk
    import t_fsk_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int HALF_1      = DEF_HALF_1,
    parameter int HALF_0      = DEF_HALF_0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              fsk_out,
    output logic              bit_clk,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(WORD_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              done_q, done_d;
`ifdef T_FSK_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic last_cyc, final_bit, accept, cur_bit, tone_restart, tone;

    // Status shared by the next-state and output logic.
    always_comb begin
        last_cyc = (state_q != IDLE) && (cnt_q == CNT_LAST);
`ifdef T_FSK_PARITY_EN
        final_bit = (state_q == PARITY);
        cur_bit   = (state_q == PARITY) ? parity_q : shift_q[WORD_W-1];
`else
        final_bit = (state_q == SEND) && (bit_idx_q == '0);
        cur_bit   = shift_q[WORD_W-1];
`endif
        accept = valid && ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
`ifdef T_FSK_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
`ifdef T_FSK_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = final_bit && last_cyc;
`ifdef T_FSK_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            SEND: begin
                if (last_cyc) begin
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - 1'b1;
                        shift_d   = shift_q << 1;
                    end else begin
`ifdef T_FSK_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef T_FSK_PARITY_EN
            PARITY: begin
                if (last_cyc) begin
                    state_d = IDLE;
                end
            end
`endif
            default: ;
        endcase
        // A new word may start from IDLE or seamlessly after the final bit.
        if (accept) begin
            state_d   = SEND;
            cnt_d     = '0;
            bit_idx_d = BW'(WORD_W - 1);
            shift_d   = data_in;
`ifdef T_FSK_PARITY_EN
            parity_d  = ^data_in;
`endif
        end
    end

    always_comb begin
        ready        = !rst && ((state_q == IDLE) || (final_bit && last_cyc));
        busy         = (state_q != IDLE);
        bit_clk      = busy && (cnt_q < CNT_HALF);
        done         = done_q;
        tone_restart = (state_q == IDLE) || last_cyc;
        fsk_out      = tone;
    end

    fsk_tone_gen #(
        .HALF_1(HALF_1),
        .HALF_0(HALF_0)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .restart (tone_restart),
        .half_sel(cur_bit),
        .tone    (tone)
    );

endmodule

// File: tb/tb_t_fsk.sv
// Scoreboard bench for t_fsk; follows T_FSK_PARITY_EN when it is defined.
// Expected bits and done times are queued at acceptance, a monitor checks the line.
module tb_t_fsk;
    import t_fsk_pkg::*;

    localparam int CPB = 256;
    localparam int H1  = 8;
    localparam int H0  = 32;
`ifdef T_FSK_PARITY_EN
    localparam int NB     = 17;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NB     = 16;
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        ready, fsk_out, bit_clk, busy, done;

    t_fsk #(.CLK_PER_BIT(CPB), .HALF_1(H1), .HALF_0(H0)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .fsk_out(fsk_out),
        .bit_clk(bit_clk),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];      // {last bit of word, bit value}
    int         done_exp_q[$]; // cycle at which done must be seen

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one bit period begins on each rising bit_clk.
    int         c = 0, edges = 0, werr = 0, idle_err = 0, half = H0;
    logic       in_bit = 1'b0;
    logic [1:0] cur = '0;
    logic       fsk_prev = 1'b0, bc_prev = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            in_bit = 1'b0;
            exp_q.delete();
            done_exp_q.delete();
        end else begin
            if (done) begin
                if (done_exp_q.size() == 0) check("done_unexpected", 1, 0);
                else check("done_cycle", cyc, done_exp_q.pop_front());
            end
            if (bit_clk && !bc_prev) begin
                if (in_bit) check("bit_len", c, CPB);
                if (exp_q.size() == 0) begin
                    check("bit_unexpected", 1, 0);
                    in_bit = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    in_bit = 1'b1;
                    c = 0;
                    edges = 0;
                    werr = 0;
                end
            end
            if (in_bit) begin
                half = cur[0] ? H1 : H0;
                if (bit_clk !== (c < CPB / 2)) werr++;
                if (fsk_out !== ((c / half) % 2 == 1)) werr++;
                if (busy !== 1'b1) werr++;
                if (ready !== (cur[1] && c == CPB - 1)) werr++;
                if (bit_clk && fsk_out && !fsk_prev) edges++;
                c++;
                if (c == CPB) begin
                    check("edges", edges, cur[0] ? 8 : 2);
                    check("bit_wave_errs", werr, 0);
                    in_bit = 1'b0;
                end
            end else if (!(bit_clk == 1'b0 && fsk_out == 1'b0 && busy == 1'b0 && ready == 1'b1)) begin
                idle_err++;
            end
        end
        fsk_prev = fsk_out;
        bc_prev  = bit_clk;
    end

    // Driver tasks start and end on a falling edge.
    task automatic send_word(input logic [15:0] w, output int acc_cyc);
        int waited = 0;
        valid   = 1'b1;
        data_in = w;
        while (!ready && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            check("accept_timeout", 0, 1);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
            for (int i = 15; i >= 0; i--) exp_q.push_back({(!PAR_EN && i == 0), w[i]});
            if (PAR_EN) exp_q.push_back({1'b1, ^w});
            done_exp_q.push_back(cyc + NB * CPB + 1);
            @(negedge clk);
        end
        valid   = 1'b0;
        data_in = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || done_exp_q.size() != 0 || in_bit) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic busy_poke(input int n);
        for (int i = 0; i < n; i++) begin
            valid   = ready ? 1'b0 : 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fsk_out"}, fsk_out, 0);
        check({tag, "_bit_clk"}, bit_clk, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, ready, 0);
    endtask

    initial begin
        int a1, a2;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        check("por_ready_after", ready, 1);

        send_word(16'hA5C3, a1);
        wait_idle();

        send_word(16'hFFFF, a1);
        send_word(16'h0000, a2);
        check("b2b_accept_cycle", a2, a1 + NB * CPB);
        wait_idle();

        send_word(16'($urandom), a1);
        busy_poke(NB * CPB + 20);
        wait_idle();

        send_word(16'h5A3C, a1);
        while (cyc < a1 + 1 + 8 * CPB + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", ready, 1);
        check("mid_rst_busy_after", busy, 0);
        send_word(16'h8001, a1);
        wait_idle();

        if (PAR_EN) begin
            send_word(16'h0001, a1);
            wait_idle();
            send_word(16'h0003, a1);
            wait_idle();
        end

        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_word(16'($urandom), a1);
        end
        wait_idle();

        check("idle_output_errs", idle_err, 0);
        check("exp_q_left", exp_q.size(), 0);
        check("done_q_left", done_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
